// File: rtl/stage3_hazard_ctrl_if.sv
// rtl/stage3_hazard_ctrl_if.sv - status/control bundle between pipeline stages and hazard unit
interface stage3_hazard_unit_if #(
  parameter int WORD_W    = 32,
  parameter int REGADDR_W = 5
);
  // status from fetch / execute / mem
  logic [REGADDR_W-1:0] rs1_e;
  logic [REGADDR_W-1:0] rs2_e;
  logic [REGADDR_W-1:0] rd_m;
  logic                 reg_write;
  logic                 csr_read;
  logic                 valid_e;
  logic                 valid_m;
  logic                 i_mem_busy;
  logic                 d_mem_busy;
  logic                 mispredict;
  logic                 fence_stall;
  logic                 halt;
  logic                 ret;
  logic [8:0]           exc_m;
  logic [WORD_W-1:0]    tvec;
  logic [WORD_W-1:0]    epc;

  // controls back to the pipeline
  logic                 pc_en;
  logic                 npc_sel;
  logic                 if_ex_stall;
  logic                 ex_mem_stall;
  logic                 if_ex_flush;
  logic                 ex_mem_flush;
  logic                 iren;
  logic                 suppress_iren;
  logic                 suppress_data;
  logic [WORD_W-1:0]    priv_pc;
  logic                 insert_priv_pc;
  logic                 trap_taken;
  logic                 halted;

  modport master (
    output rs1_e, rs2_e, rd_m, reg_write, csr_read, valid_e, valid_m,
           i_mem_busy, d_mem_busy, mispredict, fence_stall, halt, ret,
           exc_m, tvec, epc,
    input  pc_en, npc_sel, if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush,
           iren, suppress_iren, suppress_data, priv_pc, insert_priv_pc,
           trap_taken, halted
  );

  modport slave (
    input  rs1_e, rs2_e, rd_m, reg_write, csr_read, valid_e, valid_m,
           i_mem_busy, d_mem_busy, mispredict, fence_stall, halt, ret,
           exc_m, tvec, epc,
    output pc_en, npc_sel, if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush,
           iren, suppress_iren, suppress_data, priv_pc, insert_priv_pc,
           trap_taken, halted
  );
endinterface

// File: rtl/stage3_hazard_ctrl.sv
// rtl/stage3_hazard_ctrl.sv - stall/flush/redirect controller with trap drain FSM and halt park
module stage3_hazard_ctrl #(
  parameter int WORD_W    = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                CLK,
  input  logic                nRST,
  stage3_hazard_unit_if.slave hu
);

  typedef enum logic [1:0] {RUN, DRAIN, TRAP, HALT} state_t;

  state_t            state, state_n;
  logic              stale, stale_n;
  logic [WORD_W-1:0] tgt, tgt_n;
  logic              tgt_exc, tgt_exc_n;

  logic exc_any;
  logic trap_req;
  logic csr_hz;
  logic redirect;
  logic stale_fall;

  assign exc_any    = |hu.exc_m;
  assign trap_req   = (exc_any | hu.ret) & hu.valid_m;
  assign csr_hz     = hu.valid_e & hu.valid_m & hu.csr_read & hu.reg_write &
                      (hu.rd_m != '0) & ((hu.rd_m == hu.rs1_e) | (hu.rd_m == hu.rs2_e));
  // the outstanding fetch belongs to the old path; drop it as it returns
  assign stale_fall = stale & ~hu.i_mem_busy;

  // state, stale-fetch flag and captured redirect target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      stale   <= 1'b0;
      tgt     <= '0;
      tgt_exc <= 1'b0;
    end else begin
      state   <= state_n;
      stale   <= stale_n;
      tgt     <= tgt_n;
      tgt_exc <= tgt_exc_n;
    end
  end

  // next state and all pipeline controls
  always_comb begin
    state_n           = state;
    tgt_n             = tgt;
    tgt_exc_n         = tgt_exc;
    redirect          = 1'b0;
    hu.pc_en          = 1'b0;
    hu.npc_sel        = 1'b0;
    hu.if_ex_stall    = 1'b0;
    hu.ex_mem_stall   = 1'b0;
    hu.if_ex_flush    = 1'b0;
    hu.ex_mem_flush   = 1'b0;
    hu.iren           = 1'b1;
    hu.suppress_iren  = 1'b0;
    hu.suppress_data  = 1'b0;
    hu.priv_pc        = tgt;
    hu.insert_priv_pc = 1'b0;
    hu.trap_taken     = 1'b0;
    hu.halted         = 1'b0;

    case (state)
      RUN: begin
        hu.pc_en = 1'b1;
        if (hu.halt && hu.valid_m) begin
          hu.pc_en        = 1'b0;
          hu.if_ex_flush  = 1'b1;
          hu.ex_mem_flush = 1'b1;
          state_n         = HALT;
        end else if (trap_req) begin
          // exceptions outrank a simultaneous xRET
          tgt_n            = exc_any ? hu.tvec : hu.epc;
          tgt_exc_n        = exc_any;
          hu.pc_en         = 1'b0;
          hu.if_ex_stall   = 1'b1;
          hu.ex_mem_stall  = 1'b1;
          hu.suppress_data = 1'b1;
          state_n          = (hu.i_mem_busy || hu.d_mem_busy) ? DRAIN : TRAP;
        end else if (hu.mispredict && hu.valid_m) begin
          hu.npc_sel      = 1'b1;
          hu.if_ex_flush  = 1'b1;
          hu.ex_mem_flush = 1'b1;
          redirect        = 1'b1;
        end else if (hu.fence_stall || hu.d_mem_busy) begin
          hu.pc_en        = 1'b0;
          hu.if_ex_stall  = 1'b1;
          hu.ex_mem_stall = 1'b1;
        end else if (csr_hz) begin
          hu.pc_en        = 1'b0;
          hu.if_ex_stall  = 1'b1;
          hu.ex_mem_flush = 1'b1;
        end else if (hu.i_mem_busy) begin
          hu.pc_en       = 1'b0;
          hu.if_ex_stall = 1'b1;
        end
      end
      DRAIN: begin
        hu.if_ex_stall   = 1'b1;
        hu.ex_mem_stall  = 1'b1;
        hu.suppress_data = 1'b1;
        hu.suppress_iren = 1'b1;
        if (!hu.i_mem_busy && !hu.d_mem_busy) begin
          state_n = TRAP;
        end
      end
      TRAP: begin
        hu.insert_priv_pc = 1'b1;
        hu.pc_en          = 1'b1;
        hu.if_ex_flush    = 1'b1;
        hu.ex_mem_flush   = 1'b1;
        hu.trap_taken     = tgt_exc;
        redirect          = 1'b1;
        state_n           = RUN;
      end
      default: begin
        hu.halted       = 1'b1;
        hu.iren         = 1'b0;
        hu.if_ex_flush  = 1'b1;
        hu.ex_mem_flush = 1'b1;
      end
    endcase

    if (stale_fall) begin
      hu.if_ex_flush = 1'b1;
    end
  end

  // a redirect with a fetch in flight marks that fetch as stale; only one can be outstanding
  always_comb begin
    stale_n = stale;
    if (redirect && hu.i_mem_busy) begin
      stale_n = 1'b1;
    end else if (stale_fall) begin
      stale_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_stage3_hazard_ctrl.sv
// tb/tb_stage3_hazard_ctrl.sv - scoreboard bench for stage3_hazard_ctrl
module tb_stage3_hazard_ctrl;

  logic CLK;
  logic nRST;

  stage3_hazard_unit_if #(.WORD_W(32), .REGADDR_W(5)) hu ();

  stage3_hazard_ctrl #(.WORD_W(32), .REGADDR_W(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hu   (hu)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // bit order: pc_en npc_sel if_ex_stall ex_mem_stall | if_ex_flush ex_mem_flush iren suppress_iren
  //          | suppress_data insert_priv_pc trap_taken halted
  localparam logic [11:0] IDLE = 12'b1000_0010_0000;
  localparam logic [11:0] CSRB = 12'b0010_0110_0000;
  localparam logic [11:0] TREQ = 12'b0011_0010_1000;
  localparam logic [11:0] DRN  = 12'b0011_0011_1000;
  localparam logic [11:0] TRP  = 12'b1000_1110_0110;
  localparam logic [11:0] RETT = 12'b1000_1110_0100;
  localparam logic [11:0] MISP = 12'b1100_1110_0000;
  localparam logic [11:0] IBSY = 12'b0010_0010_0000;
  localparam logic [11:0] SFL  = 12'b1000_1010_0000;
  localparam logic [11:0] HLT0 = 12'b0000_1110_0000;
  localparam logic [11:0] HLTD = 12'b0000_1100_0001;

  typedef struct {
    string       nm;
    logic [11:0] bits;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic clr();
    hu.rs1_e = '0; hu.rs2_e = '0; hu.rd_m = '0;
    hu.reg_write = 1'b0; hu.csr_read = 1'b0;
    hu.valid_e = 1'b0; hu.valid_m = 1'b0;
    hu.i_mem_busy = 1'b0; hu.d_mem_busy = 1'b0;
    hu.mispredict = 1'b0; hu.fence_stall = 1'b0;
    hu.halt = 1'b0; hu.ret = 1'b0; hu.exc_m = '0;
  endtask

  // queue the expectation for the inputs currently applied, then advance one cycle
  task automatic cyc(input string nm, input logic [11:0] b, input logic [31:0] pc);
    exp_t e;
    e.nm = nm; e.bits = b; e.pc = pc;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // monitor: compare on the falling edge, away from state updates
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [11:0] act;
      e   = sb.pop_front();
      act = {hu.pc_en, hu.npc_sel, hu.if_ex_stall, hu.ex_mem_stall,
             hu.if_ex_flush, hu.ex_mem_flush, hu.iren, hu.suppress_iren,
             hu.suppress_data, hu.insert_priv_pc, hu.trap_taken, hu.halted};
      compared++;
      if (act !== e.bits) begin
        mismatched++;
        $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.bits);
      end
      compared++;
      if (hu.priv_pc !== e.pc) begin
        mismatched++;
        $display("FAIL %s priv_pc: got %h want %h", e.nm, hu.priv_pc, e.pc);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    clr();
    hu.tvec = 32'h200;
    hu.epc  = 32'h1004;
    @(posedge CLK);
    #1;
    cyc("reset", IDLE, 32'h0);
    nRST = 1'b1;
    cyc("idle", IDLE, 32'h0);

    // CSR read-after-write hazard
    hu.valid_e = 1; hu.valid_m = 1; hu.csr_read = 1; hu.reg_write = 1;
    hu.rd_m = 5'd5; hu.rs1_e = 5'd5;
    cyc("csr_rs1", CSRB, 32'h0);
    hu.rd_m = 5'd0; hu.rs1_e = 5'd0;
    cyc("csr_rd0", IDLE, 32'h0);
    hu.rd_m = 5'd7; hu.rs2_e = 5'd7;
    cyc("csr_rs2", CSRB, 32'h0);
    hu.reg_write = 0;
    cyc("csr_nowr", IDLE, 32'h0);
    clr();

    // illegal instruction, no memory busy
    hu.valid_m = 1; hu.exc_m = 9'h040;
    cyc("ill_req", TREQ, 32'h0);
    cyc("ill_trap", TRP, 32'h200);
    clr();
    cyc("ill_after", IDLE, 32'h200);

    // store fault draining a busy data access
    hu.tvec = 32'h300; hu.valid_m = 1; hu.exc_m = 9'h008; hu.d_mem_busy = 1;
    cyc("fs_req", TREQ, 32'h200);
    cyc("fs_drain1", DRN, 32'h300);
    cyc("fs_drain2", DRN, 32'h300);
    hu.d_mem_busy = 0;
    cyc("fs_drain3", DRN, 32'h300);
    cyc("fs_trap", TRP, 32'h300);
    clr();

    // xRET
    hu.valid_m = 1; hu.ret = 1;
    cyc("ret_req", TREQ, 32'h300);
    clr();
    cyc("ret_trap", RETT, 32'h1004);

    // exception outranks ret
    hu.tvec = 32'h400; hu.valid_m = 1; hu.ret = 1; hu.exc_m = 9'h002;
    cyc("excret_req", TREQ, 32'h1004);
    clr();
    cyc("excret_trap", TRP, 32'h400);
    hu.exc_m = 9'h040;
    cyc("exc_novalid", IDLE, 32'h400);
    clr();

    // mispredict with a fetch in flight
    hu.valid_m = 1; hu.mispredict = 1; hu.i_mem_busy = 1;
    cyc("misp", MISP, 32'h400);
    clr(); hu.i_mem_busy = 1;
    cyc("misp_busy", IBSY, 32'h400);
    hu.i_mem_busy = 0;
    cyc("misp_stale", SFL, 32'h400);
    cyc("misp_clean", IDLE, 32'h400);
    hu.valid_m = 1; hu.mispredict = 1;
    cyc("misp_nobusy", MISP, 32'h400);
    clr();
    cyc("misp_nostale", IDLE, 32'h400);

    // trap redirect while a fetch is in flight
    hu.tvec = 32'h500; hu.valid_m = 1; hu.exc_m = 9'h040; hu.i_mem_busy = 1;
    cyc("ib_req", TREQ, 32'h400);
    hu.i_mem_busy = 0;
    cyc("ib_drain", DRN, 32'h500);
    hu.i_mem_busy = 1;
    cyc("ib_trap", TRP, 32'h500);
    clr(); hu.i_mem_busy = 1;
    cyc("ib_busy", IBSY, 32'h500);
    hu.i_mem_busy = 0;
    cyc("ib_stale", SFL, 32'h500);
    cyc("ib_clean", IDLE, 32'h500);

    // halt beats a simultaneous exception and parks the core
    hu.tvec = 32'h600; hu.valid_m = 1; hu.halt = 1; hu.exc_m = 9'h040;
    cyc("halt_req", HLT0, 32'h500);
    hu.mispredict = 1;
    cyc("halted1", HLTD, 32'h500);
    cyc("halted2", HLTD, 32'h500);
    cyc("halted3", HLTD, 32'h500);
    clr();
    nRST = 1'b0;
    cyc("halt_rst", IDLE, 32'h0);
    nRST = 1'b1;
    cyc("halt_exit", IDLE, 32'h0);

    // reset in the middle of a drain
    hu.tvec = 32'h700; hu.valid_m = 1; hu.exc_m = 9'h008; hu.d_mem_busy = 1;
    cyc("rd_req", TREQ, 32'h0);
    cyc("rd_drain", DRN, 32'h700);
    clr();
    nRST = 1'b0;
    cyc("rd_rst", IDLE, 32'h0);
    nRST = 1'b1;
    cyc("rd_run", IDLE, 32'h0);

    @(negedge CLK);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain_sb: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
